// File: rtl/branch_metric_unit_pkg.sv
// Shared parameters, encodings and types for the radix-4 branch metric unit.
// The i_mux field offsets are shared with the convolutional encoder's trellis scan.
package branch_metric_unit_pkg;

  localparam int unsigned MAX_STATE_REG_NUM = 8;
  localparam int unsigned MAX_CODE_RATE     = 3;
  localparam int unsigned RADIX             = 4;
  localparam int unsigned MAX_STATE_NUM     = 1 << MAX_STATE_REG_NUM;
  localparam int unsigned TABLE_DEPTH       = MAX_STATE_NUM * RADIX;
  localparam int unsigned TABLE_AW          = MAX_STATE_REG_NUM + 2;
  localparam int unsigned SYM_W             = 2 * MAX_CODE_RATE;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam logic [1:0] CONSTR_K3 = 2'b00;
  localparam logic [1:0] CONSTR_K5 = 2'b01;
  localparam logic [1:0] CONSTR_K7 = 2'b10;
  localparam logic [1:0] CONSTR_K9 = 2'b11;

  localparam int unsigned MUX_DATA1_LSB = 0;
  localparam int unsigned MUX_DATA2_LSB = 3;
  localparam int unsigned MUX_STATE_LSB = 6;
  localparam int unsigned MUX_PAIR_LSB  = 14;

  typedef enum logic [1:0] {IDLE, LOAD, READY, SWEEP} bm_fsm_t;

  // Highest source state for the active constraint length.
  function automatic logic [MAX_STATE_REG_NUM-1:0] last_state(input logic [1:0] k);
    logic [MAX_STATE_REG_NUM-1:0] s;
    unique case (k)
      CONSTR_K3: s = 8'd3;
      CONSTR_K5: s = 8'd15;
      CONSTR_K7: s = 8'd63;
      default:   s = 8'd255;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Masked Hamming distance over both received symbols, 0..6.
  function automatic logic [2:0] branch_metric(input logic [SYM_W-1:0] rx,
                                                input logic [SYM_W-1:0] expd,
                                                input logic             rate);
    logic [2:0] mask;
    logic [2:0] d1;
    logic [2:0] d2;
    mask = (rate == CODE_RATE_3) ? 3'b111 : 3'b011;
    d1   = (rx[2:0] ^ expd[2:0]) & mask;
    d2   = (rx[5:3] ^ expd[5:3]) & mask;
    return {1'b0, popcount3(d1)} + {1'b0, popcount3(d2)};
  endfunction

endpackage

// File: rtl/branch_metric_unit_bm_table_ram.sv
// Transition table storage: one write port, one registered read port.
module branch_metric_unit_bm_table_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 6,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/branch_metric_unit.sv
// Radix-4 branch metric stage: captures the trellis transition table, then for each
// received symbol pair sweeps it and emits one Hamming metric per transition.
module branch_metric_unit
  import branch_metric_unit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_bm,
  input  logic                         i_code_rate,
  input  logic [1:0]                   i_constr_len,
  input  logic [15:0]                  i_mux,
  input  logic                         i_mux_valid,
  input  logic [SYM_W-1:0]             i_rx_sym,
  input  logic                         i_rx_valid,
  output logic                         o_rx_ready,
  output logic                         o_load_done,
  output logic                         o_bm_valid,
  output logic [MAX_STATE_REG_NUM-1:0] o_bm_state,
  output logic [1:0]                   o_bm_pair,
  output logic [2:0]                   o_bm_metric,
  output logic                         o_bm_last
);

  bm_fsm_t                      state_q, state_d;
  logic                         rate_q, rate_d;
  logic [1:0]                   klen_q, klen_d;
  logic [SYM_W-1:0]             rx_q, rx_d;
  logic [TABLE_AW-1:0]          addr_q, addr_d;
  logic                         issue_q, issue_d;
  logic                         p1_valid_q, p1_valid_d;
  logic                         p1_last_q, p1_last_d;
  logic [TABLE_AW-1:0]          p1_addr_q, p1_addr_d;
  logic                         rx_ready_q, rx_ready_d;
  logic                         load_done_q, load_done_d;
  logic                         bm_valid_q, bm_valid_d;
  logic [MAX_STATE_REG_NUM-1:0] bm_state_q, bm_state_d;
  logic [1:0]                   bm_pair_q, bm_pair_d;
  logic [2:0]                   bm_metric_q, bm_metric_d;
  logic                         bm_last_q, bm_last_d;

  logic                         ram_we;
  logic [TABLE_AW-1:0]          ram_waddr;
  logic [SYM_W-1:0]             ram_rdata;
  logic [MAX_STATE_REG_NUM-1:0] mux_state;
  logic [1:0]                   mux_pair;
  logic [TABLE_AW-1:0]          last_addr;

  assign mux_state = i_mux[MUX_STATE_LSB +: MAX_STATE_REG_NUM];
  assign mux_pair  = i_mux[MUX_PAIR_LSB +: 2];
  assign ram_waddr = {mux_state, mux_pair};
  assign last_addr = {last_state(klen_q), 2'b11};

  branch_metric_unit_bm_table_ram #(
    .Depth (TABLE_DEPTH),
    .Width (SYM_W),
    .AddrW (TABLE_AW)
  ) u_table (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (i_mux[MUX_DATA1_LSB +: SYM_W]),
    .raddr_i (addr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    klen_d      = klen_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    issue_d     = issue_q;
    rx_ready_d  = rx_ready_q;
    load_done_d = load_done_q;
    ram_we      = 1'b0;

    // Stage 1 tracks the address whose table read is in flight.
    p1_valid_d = issue_q;
    p1_last_d  = issue_q && (addr_q == last_addr);
    p1_addr_d  = addr_q;

    // Stage 2 turns the read data into the registered metric.
    bm_valid_d  = p1_valid_q;
    bm_last_d   = p1_valid_q && p1_last_q;
    bm_state_d  = p1_valid_q ? p1_addr_q[TABLE_AW-1:2] : '0;
    bm_pair_d   = p1_valid_q ? p1_addr_q[1:0] : '0;
    bm_metric_d = p1_valid_q ? branch_metric(rx_q, ram_rdata, rate_q) : '0;

    unique case (state_q)
      IDLE: begin
        if (en_bm) begin
          rate_d  = i_code_rate;
          klen_d  = i_constr_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (i_mux_valid) begin
          ram_we = 1'b1;
          if (mux_state == last_state(klen_q) && mux_pair == 2'b11) begin
            state_d     = READY;
            load_done_d = 1'b1;
            rx_ready_d  = 1'b1;
          end
        end
      end
      READY: begin
        if (i_rx_valid) begin
          rx_d       = i_rx_sym;
          rx_ready_d = 1'b0;
          addr_d     = '0;
          issue_d    = 1'b1;
          state_d    = SWEEP;
        end
      end
      SWEEP: begin
        if (issue_q) begin
          addr_d = addr_q + TABLE_AW'(1);
          if (addr_q == last_addr) begin
            issue_d = 1'b0;
          end
        end
        // Hold off the next accept until the final metric has left the pipeline.
        if (bm_last_q) begin
          state_d    = READY;
          rx_ready_d = 1'b1;
        end
      end
    endcase

    if (!en_bm) begin
      state_d     = IDLE;
      issue_d     = 1'b0;
      ram_we      = 1'b0;
      rx_ready_d  = 1'b0;
      load_done_d = 1'b0;
      p1_valid_d  = 1'b0;
      p1_last_d   = 1'b0;
      bm_valid_d  = 1'b0;
      bm_last_d   = 1'b0;
      bm_state_d  = '0;
      bm_pair_d   = '0;
      bm_metric_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rate_q      <= 1'b0;
      klen_q      <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      issue_q     <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_addr_q   <= '0;
      rx_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      bm_valid_q  <= 1'b0;
      bm_state_q  <= '0;
      bm_pair_q   <= '0;
      bm_metric_q <= '0;
      bm_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      klen_q      <= klen_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      issue_q     <= issue_d;
      p1_valid_q  <= p1_valid_d;
      p1_last_q   <= p1_last_d;
      p1_addr_q   <= p1_addr_d;
      rx_ready_q  <= rx_ready_d;
      load_done_q <= load_done_d;
      bm_valid_q  <= bm_valid_d;
      bm_state_q  <= bm_state_d;
      bm_pair_q   <= bm_pair_d;
      bm_metric_q <= bm_metric_d;
      bm_last_q   <= bm_last_d;
    end
  end

  assign o_rx_ready  = rx_ready_q;
  assign o_load_done = load_done_q;
  assign o_bm_valid  = bm_valid_q;
  assign o_bm_state  = bm_state_q;
  assign o_bm_pair   = bm_pair_q;
  assign o_bm_metric = bm_metric_q;
  assign o_bm_last   = bm_last_q;

endmodule

// File: tb/tb_branch_metric_unit.sv
// Randomized scoreboard bench for branch_metric_unit against a table-level reference model.
module tb_branch_metric_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_bm = 1'b0;
  logic        i_code_rate = 1'b0;
  logic [1:0]  i_constr_len = 2'b00;
  logic [15:0] i_mux = '0;
  logic        i_mux_valid = 1'b0;
  logic [5:0]  i_rx_sym = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready, o_load_done, o_bm_valid, o_bm_last;
  logic [7:0]  o_bm_state;
  logic [1:0]  o_bm_pair;
  logic [2:0]  o_bm_metric;

  branch_metric_unit dut (
    .clk          (clk),
    .rst          (rst),
    .en_bm        (en_bm),
    .i_code_rate  (i_code_rate),
    .i_constr_len (i_constr_len),
    .i_mux        (i_mux),
    .i_mux_valid  (i_mux_valid),
    .i_rx_sym     (i_rx_sym),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_load_done  (o_load_done),
    .o_bm_valid   (o_bm_valid),
    .o_bm_state   (o_bm_state),
    .o_bm_pair    (o_bm_pair),
    .o_bm_metric  (o_bm_metric),
    .o_bm_last    (o_bm_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] st;
    logic [1:0] pr;
    logic [2:0] m;
    logic       lst;
  } exp_t;

  exp_t       sb_q[$];
  int         sb_cyc[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         n_metrics = 0;
  int         n_accepts = 0;
  logic [5:0] tbl [256][4];
  int         ns_cur = 4;
  logic       rate_cur = 1'b0;
  exp_t       mon_e;
  int         mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] all_out();
    return {o_rx_ready, o_load_done, o_bm_valid, o_bm_state, o_bm_pair, o_bm_metric, o_bm_last};
  endfunction

  // Hamming distance of the bits the code rate actually transmits.
  function automatic int ref_metric(input logic [5:0] d, input logic [5:0] rx, input logic rate);
    logic [2:0] mask;
    mask = rate ? 3'b111 : 3'b011;
    return $countones((d[2:0] ^ rx[2:0]) & mask) + $countones((d[5:3] ^ rx[5:3]) & mask);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rx_ready && i_rx_valid) n_accepts <= n_accepts + 1;
  end

  // Monitor: every presented metric must match the next expected one, on its expected cycle.
  always @(negedge clk) begin
    if (o_bm_valid) begin
      n_metrics++;
      if (sb_q.size() == 0) begin
        check("unexpected_metric", 32'(o_bm_valid), 32'(0));
      end else begin
        mon_e = sb_q.pop_front();
        mon_c = sb_cyc.pop_front();
        check("bm_fields", 32'({o_bm_state, o_bm_pair, o_bm_metric, o_bm_last}), 32'(mon_e));
        check("bm_cycle", 32'(cyc), 32'(mon_c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enable(input logic rate, input logic [1:0] k);
    en_bm = 1'b0;
    tick();
    i_code_rate  = rate;
    i_constr_len = k;
    en_bm        = 1'b1;
    tick();
    rate_cur     = rate;
    ns_cur       = 4 << (2 * int'(k));
    i_code_rate  = ~rate;
    i_constr_len = ~k;
  endtask

  task automatic write_entry(input int s, input int p, input logic [5:0] d);
    i_mux       = {2'(p), 8'(s), d};
    i_mux_valid = 1'b1;
    tbl[s][p]   = d;
    tick();
    i_mux_valid = 1'b0;
  endtask

  task automatic load_table(input bit shuffle);
    int n;
    int order[$];
    n = ns_cur * 4;
    for (int a = 0; a < n - 1; a++) order.push_back(a);
    if (shuffle) begin
      for (int i = n - 2; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(i, 0));
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      order.push_back(int'($urandom_range(n - 2, 2)));
    end
    foreach (order[i]) begin
      if (shuffle && $urandom_range(1, 0) == 1) begin
        i_mux = 16'($urandom);
        tick();
      end
      // State 0, pairs 0/1 hold all-zero data so the rate-mask cases are exercised.
      write_entry(order[i] / 4, order[i] % 4, (order[i] < 2) ? 6'd0 : 6'($urandom));
    end
    check("load_done_before_last", 32'(o_load_done), 32'(0));
    write_entry(ns_cur - 1, 3, 6'($urandom));
    check("load_done_after_last", 32'(o_load_done), 32'(1));
    check("ready_after_load", 32'(o_rx_ready), 32'(1));
  endtask

  task automatic push_expected(input logic [5:0] rx, input int t);
    int idx;
    idx = 0;
    for (int s = 0; s < ns_cur; s++) begin
      for (int p = 0; p < 4; p++) begin
        exp_t e;
        e.st  = 8'(s);
        e.pr  = 2'(p);
        e.m   = 3'(ref_metric(tbl[s][p], rx, rate_cur));
        e.lst = (s == ns_cur - 1) && (p == 3);
        sb_q.push_back(e);
        sb_cyc.push_back(t + 2 + idx);
        idx++;
      end
    end
  endtask

  // Offers rx and returns the edge number at which it is accepted, or -1.
  task automatic handshake(input logic [5:0] rx, output int t);
    bit ok;
    tick();
    i_rx_sym   = rx;
    i_rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("handshake_seen", 32'(ok), 32'(1));
    t = ok ? cyc + 1 : -1;
  endtask

  task automatic sweep(input logic [5:0] rx, input bit hold);
    int t;
    int n;
    int m0;
    int a0;
    n = ns_cur * 4;
    handshake(rx, t);
    if (t < 0) begin
      i_rx_valid = 1'b0;
      return;
    end
    m0 = n_metrics;
    a0 = n_accepts;
    push_expected(rx, t);
    tick();
    if (!hold) i_rx_valid = 1'b0;
    i_rx_sym = 6'($urandom);
    while (cyc < t + n + 1) @(negedge clk);
    check("ready_low_at_last", 32'(o_rx_ready), 32'(0));
    i_rx_valid = 1'b0;
    @(negedge clk);
    check("ready_after_sweep", 32'(o_rx_ready), 32'(1));
    check("metric_count", 32'(n_metrics - m0), 32'(n));
    check("accepts_per_sweep", 32'(n_accepts - a0), 32'(1));
    check("sb_drained", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic abort_sweep(input bit use_rst);
    int t;
    handshake(6'($urandom), t);
    if (t >= 0) push_expected(i_rx_sym, t);
    tick();
    i_rx_valid = 1'b0;
    repeat (10) tick();
    if (use_rst) rst = 1'b0;
    else en_bm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(use_rst ? "rst_abort_valid" : "en_abort_valid", 32'(o_bm_valid), 32'(0));
    check(use_rst ? "rst_abort_outputs" : "en_abort_outputs", 32'(all_out()), 32'(0));
    sb_q.delete();
    sb_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with the block enabled and noisy inputs.
    rst   = 1'b0;
    en_bm = 1'b1;
    @(posedge clk);
    repeat (5) begin
      i_mux        = 16'($urandom);
      i_mux_valid  = 1'($urandom);
      i_rx_sym     = 6'($urandom);
      i_rx_valid   = 1'($urandom);
      i_code_rate  = 1'($urandom);
      i_constr_len = 2'($urandom);
      @(negedge clk);
      check("reset_outputs", 32'(all_out()), 32'(0));
    end
    i_code_rate  = 1'b0;
    i_constr_len = 2'b00;
    i_mux_valid  = 1'b0;
    i_rx_valid   = 1'b1;
    rst          = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_low_in_load", 32'(o_rx_ready), 32'(0));
    end
    i_rx_valid = 1'b0;
    rate_cur   = 1'b0;
    ns_cur     = 4;
    tick();

    // K=3, rate 1/2, in-order load.
    load_table(1'b0);
    sweep(6'b000_000, 1'b0);
    // Writes outside LOAD must not reach the table.
    i_mux       = 16'h003F;
    i_mux_valid = 1'b1;
    repeat (2) tick();
    i_mux_valid = 1'b0;
    sweep(6'b100_100, 1'b0);
    for (int i = 0; i < 3; i++) sweep(6'($urandom), 1'(i == 1));

    // K=3, rate 1/3, shuffled load with a rewrite.
    enable(1'b1, 2'b00);
    load_table(1'b1);
    sweep(6'b100_100, 1'b0);
    sweep(6'b111_111, 1'b0);

    // K=5, random rate.
    enable(1'($urandom), 2'b01);
    load_table(1'b1);
    sweep(6'($urandom), 1'b0);

    // K=9 full table, rx valid held through the sweep.
    enable(1'($urandom), 2'b11);
    load_table(1'b0);
    sweep(6'($urandom), 1'b1);
    abort_sweep(1'b0);

    // Reset mid-sweep.
    enable(1'b0, 2'b00);
    load_table(1'b0);
    abort_sweep(1'b1);
    rst = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
